register_file_mp: RTL and testbench
===================================

Name: register_file_mp

Overview:
- Parametrised multi-port successor to the 32x32 register file used by the pipelined CPU core.
- Configurable width, depth, read-port count and write-port count; register 0 is hardwired to zero.
- Write-through bypass on every read port.
- Per-register busy scoreboard: reserved by the issue stage, released on writeback, bulk-cleared on flush. Read ports report busy alongside data, so the hazard unit can stall on not-yet-written operands.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of registers; power of two, at least 2.
- NREAD, 2, number of read ports, at least 1.
- NWRITE, 1, number of write ports, at least 1.

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- WEN  in  NWRITE  per-port write enable.
- wsel  in  NWRITE x log2(NREG)  per-port write register select.
- wdat  in  NWRITE x DW  per-port write data.
- rsel  in  NREAD x log2(NREG)  per-port read register select.
- rdat  out  NREAD x DW  per-port read data.
- rbusy  out  NREAD  busy bit of the register selected by rsel[i].
- rsv_en  in  1  reserve request from issue stage.
- rsv_sel  in  log2(NREG)  register to reserve.
- flush  in  1  clear all busy bits.
- busy_cnt  out  log2(NREG)+1  number of registers currently busy (registered).

Behaviour:
- Reset: RST high at a rising edge sets all registers, all busy bits and busy_cnt to 0. While RST is high, writes, reservations and flush are ignored. rdat follows the cleared array (0) by the next edge.
- Write: on each edge, for every port w with WEN[w] high and wsel[w] not 0, set reg[wsel[w]] to wdat[w].
- Write conflict: if several ports write the same register in one cycle, the highest-indexed port wins.
- Register 0: writes to register 0 are discarded. rdat for rsel 0 is always 0 and rbusy for rsel 0 is always 0.
- Read: combinational, zero latency.
- Bypass: if any port w in the current cycle has WEN[w] high and wsel[w] equal to rsel[i] (nonzero), rdat[i] returns the winning wdat instead of the stored value. The winner is chosen by the same priority rule as the write conflict.
- Busy set: rsv_en high with rsv_sel nonzero sets busy[rsv_sel] at the edge.
- Busy clear: any enabled write to register r clears busy[r] at the edge.
- Same-cycle reserve and write to the same register: the reserve wins and busy stays 1. The data is still written, since a new producer has been issued.
- flush: clears all busy bits at the edge and overrides a reserve in the same cycle. Writes in that cycle still update data.
- rbusy[i]: reflects the busy bit after the current cycle's writes, matching the bypass. It is 0 if a same-cycle write targets rsel[i] and no same-cycle reserve targets rsel[i]. A same-cycle reserve is not visible until the next cycle.
- busy_cnt: registered popcount of the busy vector. It updates the cycle after the busy bits change; its range is 0..NREG-1.
- X on wsel/rsel when the matching enable is low has no effect.

Decomposition:
- cpu_types_pkg holds:
  - word_t (DW = 32 default);
  - regsel_t (log2(NREG) bits);
  - REG_ZERO constant;
  - a priority-select function that returns the winning write port for a given select.
- One sub-module, regfile_scoreboard: owns the busy vector, the set/clear/flush priority and busy_cnt, and exposes a busy lookup per read port.
- The data array and bypass mux stay in register_file_mp.

Test Plan:
1. Reset: write regs 1..31 with nonzero values, assert RST for 1 cycle, then read all regs on every port -> all rdat = 0, rbusy = 0, busy_cnt = 0.
2. Write/read sweep with NREAD=2, NWRITE=1: write random data to regs 0..31, then read each on both ports -> reg 0 reads 0, every other register matches the written data.
3. Bypass and priority with NWRITE=2: port0 writes 0xAAAA_0000 to reg 5 while port1 writes 0x5555_FFFF to reg 5 and rsel[0]=5 -> rdat[0] = 0x5555_FFFF in the same cycle; stored value is 0x5555_FFFF the next cycle.
4. Scoreboard: reserve reg 7, then 2 idle cycles -> rbusy = 1 and busy_cnt = 1. Write reg 7 with 0x1234 -> rbusy = 0 in the same cycle, busy_cnt = 0 one cycle later.
5. Simultaneous events:
   - Reserve reg 9 and write reg 9 in one cycle -> busy stays 1 and the data is updated.
   - Reserve regs 3, 4, 6, then flush while reserving reg 8 -> busy_cnt = 0 and reg 8 is not busy.
6. Reset mid-operation: regs 1..4 reserved and writes in flight, assert RST -> the write is discarded, busy_cnt = 0, and all rdat = 0 on the following cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types and helpers for the multi-port register file and its scoreboard.
package cpu_types_pkg;

  localparam int DW_DEF    = 32;
  localparam int NREG_DEF  = 32;
  localparam int MAX_PORTS = 32;

  typedef logic [DW_DEF-1:0]           word_t;
  typedef logic [$clog2(NREG_DEF)-1:0] regsel_t;

  localparam regsel_t REG_ZERO = '0;

  // Highest-indexed set bit wins, so later write ports take priority.
  function automatic int win_port(input logic [MAX_PORTS-1:0] hits);
    win_port = 0;
    for (int k = 0; k < MAX_PORTS; k++) begin
      if (hits[k]) win_port = k;
    end
  endfunction

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle between the CPU pipeline (master) and the register file (slave).
interface register_file_mp_if #(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
);
  localparam int SW = $clog2(NREG);

  logic [NWRITE-1:0] WEN;
  logic [SW-1:0]     wsel [NWRITE];
  logic [DW-1:0]     wdat [NWRITE];
  logic [SW-1:0]     rsel [NREAD];
  logic [DW-1:0]     rdat [NREAD];
  logic [NREAD-1:0]  rbusy;
  logic              rsv_en;
  logic [SW-1:0]     rsv_sel;
  logic              flush;
  logic [SW:0]       busy_cnt;

  modport master (
    output WEN, wsel, wdat, rsel, rsv_en, rsv_sel, flush,
    input  rdat, rbusy, busy_cnt
  );

  modport slave (
    input  WEN, wsel, wdat, rsel, rsv_en, rsv_sel, flush,
    output rdat, rbusy, busy_cnt
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Per-register busy tracking: reserve sets, writeback clears, flush clears all.
module regfile_scoreboard #(
  parameter int  NREG   = 32,
  parameter int  NREAD  = 2,
  parameter int  NWRITE = 1,
  localparam int SW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NWRITE-1:0] wen,
  input  logic [SW-1:0]     wsel [NWRITE],
  input  logic              rsv_en,
  input  logic [SW-1:0]     rsv_sel,
  input  logic              flush,
  input  logic [SW-1:0]     rsel [NREAD],
  output logic [NREAD-1:0]  rbusy,
  output logic [SW:0]       busy_cnt
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;

  function automatic logic [SW:0] popcount(input logic [NREG-1:0] v);
    popcount = '0;
    for (int r = 0; r < NREG; r++) begin
      popcount = popcount + {{SW{1'b0}}, v[r]};
    end
  endfunction

  // Priority low to high: writeback clear, reserve set, flush.
  always_comb begin
    busy_nxt = busy;
    for (int r = 1; r < NREG; r++) begin
      for (int w = 0; w < NWRITE; w++) begin
        if (wen[w] && (wsel[w] == SW'(r))) busy_nxt[r] = 1'b0;
      end
    end
    if (rsv_en && (rsv_sel != '0)) busy_nxt[rsv_sel] = 1'b1;
    if (flush) busy_nxt = '0;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= popcount(busy_nxt);
    end
  end

  // A same-cycle writeback hides the busy bit unless a new reserve also targets it.
  always_comb begin : busy_lookup
    logic whit;
    logic rhit;
    for (int i = 0; i < NREAD; i++) begin
      whit = 1'b0;
      for (int w = 0; w < NWRITE; w++) begin
        whit = whit | (wen[w] && (wsel[w] == rsel[i]));
      end
      rhit     = rsv_en && (rsv_sel == rsel[i]);
      rbusy[i] = busy[rsel[i]] && !(whit && !rhit);
      if (rsel[i] == '0) rbusy[i] = 1'b0;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file with write-through bypass and a busy scoreboard; reg 0 reads as zero.
module register_file_mp
  import cpu_types_pkg::*;
#(
  parameter int DW     = 32,
  parameter int NREG   = 32,
  parameter int NREAD  = 2,
  parameter int NWRITE = 1
) (
  input logic              CLK,
  input logic              RST,
  register_file_mp_if.slave bus
);

  localparam int SW = $clog2(NREG);
  localparam logic [SW-1:0] ZSEL = SW'(REG_ZERO);

  logic [DW-1:0]     regs [NREG];
  logic [NWRITE-1:0] wen_eff;

  // Writes are suppressed entirely while reset is held, including the bypass path.
  assign wen_eff = RST ? '0 : bus.WEN;

  // Later ports overwrite earlier ones within the loop, giving highest-index priority.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int r = 0; r < NREG; r++) regs[r] <= '0;
    end else begin
      for (int w = 0; w < NWRITE; w++) begin
        if (bus.WEN[w] && (bus.wsel[w] != ZSEL)) regs[bus.wsel[w]] <= bus.wdat[w];
      end
    end
  end

  always_comb begin : rd_mux
    logic [MAX_PORTS-1:0] hits;
    int                   win;
    for (int i = 0; i < NREAD; i++) begin
      hits = '0;
      for (int w = 0; w < NWRITE; w++) begin
        hits[w] = wen_eff[w] && (bus.wsel[w] == bus.rsel[i]);
      end
      win         = win_port(hits);
      bus.rdat[i] = regs[bus.rsel[i]];
      if (|hits) begin
        for (int w = 0; w < NWRITE; w++) begin
          if (w == win) bus.rdat[i] = bus.wdat[w];
        end
      end
      if (bus.rsel[i] == ZSEL) bus.rdat[i] = '0;
    end
  end

  regfile_scoreboard #(
    .NREG   (NREG),
    .NREAD  (NREAD),
    .NWRITE (NWRITE)
  ) u_sb (
    .clk      (CLK),
    .rst      (RST),
    .wen      (wen_eff),
    .wsel     (bus.wsel),
    .rsv_en   (bus.rsv_en),
    .rsv_sel  (bus.rsv_sel),
    .flush    (bus.flush),
    .rsel     (bus.rsel),
    .rbusy    (bus.rbusy),
    .busy_cnt (bus.busy_cnt)
  );

endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench for register_file_mp (2 read, 2 write ports) with an expected-value queue.
module tb_register_file_mp;
  import cpu_types_pkg::*;

  localparam int NR = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  register_file_mp_if #(.DW(32), .NREG(NR), .NREAD(2), .NWRITE(2)) bus ();

  register_file_mp #(.DW(32), .NREG(NR), .NREAD(2), .NWRITE(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  word_t expq [$];
  word_t mdl  [NR];
  int    total = 0;
  int    bad   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle();
    bus.WEN    = '0;
    bus.rsv_en = 1'b0;
    bus.flush  = 1'b0;
  endtask

  task automatic push(input word_t e);
    expq.push_back(e);
  endtask

  task automatic chk(input string tag, input word_t obs);
    word_t e;
    total++;
    if (expq.size() == 0) begin
      bad++;
      $error("FAIL %s: no expected value queued, observed %0h", tag, obs);
    end else begin
      e = expq.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
      end
    end
  endtask

  task automatic wr(input int port, input int r, input word_t d);
    bus.WEN[port]  = 1'b1;
    bus.wsel[port] = 5'(r);
    bus.wdat[port] = d;
  endtask

  task automatic rsv(input int r);
    bus.rsv_en  = 1'b1;
    bus.rsv_sel = 5'(r);
  endtask

  task automatic rd(input int r0, input int r1);
    bus.rsel[0] = 5'(r0);
    bus.rsel[1] = 5'(r1);
  endtask

  initial begin
    word_t d;
    idle();
    bus.wsel[0] = REG_ZERO; bus.wsel[1] = REG_ZERO;
    bus.wdat[0] = '0;       bus.wdat[1] = '0;
    bus.rsv_sel = REG_ZERO;
    rd(0, 0);
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset clears previously written contents
    for (int r = 1; r < NR; r++) begin
      idle(); wr(0, r, 32'h1000_0000 | 32'(r)); tick();
    end
    idle(); rd(31, 17);
    push(32'h1000_001f); push(32'h1000_0011);
    settle(); chk("pre_reset_r31", bus.rdat[0]); chk("pre_reset_r17", bus.rdat[1]);
    rst = 1'b1; tick(); rst = 1'b0;
    push(32'd0); settle(); chk("reset_busy_cnt", 32'(bus.busy_cnt));
    for (int r = 0; r < NR; r++) begin
      rd(r, NR - 1 - r);
      push(32'd0); push(32'd0); push(32'd0); push(32'd0);
      settle();
      chk("reset_rdat0", bus.rdat[0]); chk("reset_rdat1", bus.rdat[1]);
      chk("reset_rbusy0", 32'(bus.rbusy[0])); chk("reset_rbusy1", 32'(bus.rbusy[1]));
      tick();
    end

    // Write/read sweep on port 0
    for (int r = 0; r < NR; r++) begin
      d = $urandom | 32'h1;
      mdl[r] = (r == 0) ? 32'd0 : d;
      idle(); wr(0, r, d); tick();
    end
    idle(); bus.wsel[0] = 'x; bus.wsel[1] = 'x;
    for (int r = 0; r < NR; r++) begin
      rd(r, r);
      push(mdl[r]); push(mdl[r]);
      settle();
      chk("sweep_rdat0", bus.rdat[0]); chk("sweep_rdat1", bus.rdat[1]);
      tick();
    end

    // Bypass with write-port priority
    idle(); wr(0, 5, 32'hAAAA_0000); wr(1, 5, 32'h5555_FFFF); rd(5, 6);
    push(32'h5555_FFFF); push(mdl[6]);
    settle(); chk("bypass_prio", bus.rdat[0]); chk("bypass_other_reg", bus.rdat[1]);
    tick(); idle();
    push(32'h5555_FFFF); settle(); chk("prio_stored", bus.rdat[0]);
    idle(); wr(0, 6, 32'hCAFE_0006); wr(1, 0, 32'hFFFF_FFFF); rd(0, 6);
    push(32'd0); push(32'hCAFE_0006);
    settle(); chk("bypass_reg0", bus.rdat[0]); chk("bypass_port0", bus.rdat[1]);
    tick(); idle(); rd(0, 6);
    push(32'd0); push(32'hCAFE_0006);
    settle(); chk("reg0_discard", bus.rdat[0]); chk("port0_stored", bus.rdat[1]);

    // Scoreboard reserve/release; reg 0 never becomes busy
    idle(); rsv(0); tick(); idle(); rd(0, 0);
    push(32'd0); push(32'd0);
    settle(); chk("rsv_reg0_cnt", 32'(bus.busy_cnt)); chk("rsv_reg0_rbusy", 32'(bus.rbusy[0]));
    idle(); rsv(7); tick(); idle(); tick(); tick(); rd(7, 7);
    push(32'd1); push(32'd1); push(32'd1);
    settle();
    chk("rsv7_rbusy0", 32'(bus.rbusy[0])); chk("rsv7_rbusy1", 32'(bus.rbusy[1]));
    chk("rsv7_cnt", 32'(bus.busy_cnt));
    idle(); wr(0, 7, 32'h0000_1234);
    push(32'd0); push(32'h0000_1234); push(32'd1);
    settle();
    chk("wb7_rbusy_same", 32'(bus.rbusy[0])); chk("wb7_bypass", bus.rdat[0]);
    chk("wb7_cnt_same", 32'(bus.busy_cnt));
    tick(); idle();
    push(32'd0); push(32'd0); push(32'h0000_1234);
    settle();
    chk("wb7_cnt_next", 32'(bus.busy_cnt)); chk("wb7_rbusy_next", 32'(bus.rbusy[0]));
    chk("wb7_stored", bus.rdat[0]);

    // Same-cycle reserve and write: reserve wins, data still written
    idle(); rsv(9); wr(0, 9, 32'h9999_0009); rd(9, 9);
    push(32'h9999_0009); settle(); chk("rsv_wr9_bypass", bus.rdat[0]);
    tick(); idle();
    push(32'd1); push(32'h9999_0009); push(32'd1);
    settle();
    chk("rsv_wr9_busy", 32'(bus.rbusy[0])); chk("rsv_wr9_data", bus.rdat[0]);
    chk("rsv_wr9_cnt", 32'(bus.busy_cnt));

    // Flush overrides a same-cycle reserve; writes still land
    idle(); rsv(3); tick(); idle(); rsv(4); tick(); idle(); rsv(6); tick(); idle();
    push(32'd4); settle(); chk("pre_flush_cnt", 32'(bus.busy_cnt));
    idle(); bus.flush = 1'b1; rsv(8); wr(0, 3, 32'h3333_0003); tick(); idle(); rd(8, 3);
    push(32'd0); push(32'd0); push(32'h3333_0003); push(32'd0);
    settle();
    chk("flush_cnt", 32'(bus.busy_cnt)); chk("flush_rbusy8", 32'(bus.rbusy[0]));
    chk("flush_write3", bus.rdat[1]); chk("flush_rbusy3", 32'(bus.rbusy[1]));

    // Reset in the middle of reservations and writes
    for (int r = 1; r <= 4; r++) begin
      idle(); rsv(r); tick();
    end
    idle(); rd(1, 4);
    push(32'd4); push(32'd1); push(32'd1);
    settle();
    chk("mid_cnt", 32'(bus.busy_cnt)); chk("mid_rbusy1", 32'(bus.rbusy[0]));
    chk("mid_rbusy4", 32'(bus.rbusy[1]));
    idle(); wr(0, 2, 32'hDEAD_0002); wr(1, 3, 32'hBEEF_0003); rsv(5);
    rst = 1'b1; tick(); rst = 1'b0; idle(); rd(2, 3);
    push(32'd0); push(32'd0); push(32'd0); push(32'd0); push(32'd0);
    settle();
    chk("mid_rst_cnt", 32'(bus.busy_cnt)); chk("mid_rst_r2", bus.rdat[0]);
    chk("mid_rst_r3", bus.rdat[1]); chk("mid_rst_rbusy2", 32'(bus.rbusy[0]));
    chk("mid_rst_rbusy3", 32'(bus.rbusy[1]));
    tick();
    for (int r = 0; r < NR; r++) begin
      rd(r, NR - 1 - r);
      push(32'd0); push(32'd0);
      settle();
      chk("mid_rst_rdat0", bus.rdat[0]); chk("mid_rst_rdat1", bus.rdat[1]);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
